// File: rtl/fp32_pkg.sv
// Shared single-precision helpers: FSM state type, field constants and the
// unpack/classify functions used by the divider and the multiplier.
package fp32_pkg;

  localparam int FP_W      = 32;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  localparam int FP_BIAS   = 127;

  localparam logic [FP_W-1:0]     FP_QNAN    = 32'h7FC00000;
  localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_NORM,
    S_DONE
  } fp_state_t;

  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } fp_class_t;

  function automatic logic fp_sign(input logic [FP_W-1:0] x);
    return x[FP_W-1];
  endfunction

  function automatic logic [FP_EXP_W-1:0] fp_exp(input logic [FP_W-1:0] x);
    return x[FP_W-2 -: FP_EXP_W];
  endfunction

  function automatic logic [FP_MANT_W-1:0] fp_mant(input logic [FP_W-1:0] x);
    return x[FP_MANT_W-1:0];
  endfunction

  // Exponent 0 is treated as zero (denormals flush), all-ones is inf/NaN.
  function automatic fp_class_t fp_classify(input logic [FP_W-1:0] x);
    fp_class_t cl;
    cl.is_zero = (fp_exp(x) == '0);
    cl.is_inf  = (fp_exp(x) == FP_EXP_MAX) && (fp_mant(x) == '0);
    cl.is_nan  = (fp_exp(x) == FP_EXP_MAX) && (fp_mant(x) != '0);
    return cl;
  endfunction

endpackage

// File: rtl/mant_div_core.sv
// Restoring mantissa divider: one quotient bit per cycle, W+1 bits total.
// Produces q = floor(dividend * 2^W / divisor) for dividend < 2*divisor.
module mant_div_core #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W:0]   q,
  output logic         last
);

  localparam int CW = $clog2(W + 1);

  logic [W:0]    r_rem;
  logic [W:0]    r_q;
  logic [CW-1:0] r_cnt;
  logic          r_run;
  logic          r_last;

  logic          w_ge;
  logic [W-1:0]  w_diff;

  // Trial subtraction; the remainder stays below the divisor afterwards, so
  // W bits suffice before the shift.
  always_comb begin
    w_ge   = (r_rem >= {1'b0, divisor});
    w_diff = w_ge ? W'(r_rem - {1'b0, divisor}) : r_rem[W-1:0];
  end

  // Iterate W+1 times after load, then stop and pulse last for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_last <= 1'b0;
    end else begin
      r_last <= 1'b0;
      if (load) begin
        r_rem <= {1'b0, dividend};
        r_q   <= '0;
        r_cnt <= CW'(W);
        r_run <= 1'b1;
      end else if (r_run) begin
        r_rem <= {w_diff, 1'b0};
        r_q   <= {r_q[W-1:0], w_ge};
        if (r_cnt == '0) begin
          r_run  <= 1'b0;
          r_last <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign q    = r_q;
  assign last = r_last;

endmodule

// File: rtl/ieee_divide.sv
// Sequential single-precision divider c = a / b with truncated result.
// Special operands finish in one cycle; normal operands run the restoring
// mantissa divider and are then normalised with overflow/underflow clamps.
module ieee_divide
  import fp32_pkg::*;
#(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8,
  parameter int BIAS   = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] c
);

  localparam int QW  = MANT_W + 2;
  localparam int EXW = EXP_W + 2;
  localparam logic signed [EXW-1:0] BIAS_HI = EXW'(BIAS);
  localparam logic signed [EXW-1:0] BIAS_LO = EXW'(BIAS - 1);
  localparam logic signed [EXW-1:0] EX_MAX  = EXW'((1 << EXP_W) - 1);

  fp_state_t           r_state;
  logic                r_busy;
  logic                r_done;
  logic [31:0]         r_c;
  logic                r_sign;
  logic [EXP_W-1:0]    r_ea;
  logic [EXP_W-1:0]    r_eb;
  logic [MANT_W:0]     r_mb;

  fp_class_t           w_ca;
  fp_class_t           w_cb;
  logic                w_sign;
  logic                w_special;
  logic [31:0]         w_spec_c;
  logic [MANT_W:0]     w_ma;
  logic [MANT_W:0]     w_mb;
  logic                w_load;
  logic [QW-1:0]       w_q;
  logic                w_last;
  logic signed [EXW-1:0] w_ex;
  logic [MANT_W-1:0]   w_mant;
  logic [31:0]         w_norm_c;

  // Operand unpack and special-case resolution, in priority order.
  always_comb begin
    w_ca      = fp_classify(a);
    w_cb      = fp_classify(b);
    w_sign    = fp_sign(a) ^ fp_sign(b);
    w_ma      = {|fp_exp(a), fp_mant(a)};
    w_mb      = {|fp_exp(b), fp_mant(b)};
    w_special = 1'b1;
    w_spec_c  = '0;
    if (w_ca.is_nan || w_cb.is_nan || (w_ca.is_zero && w_cb.is_zero) ||
        (w_ca.is_inf && w_cb.is_inf)) begin
      w_spec_c = FP_QNAN;
    end else if (w_ca.is_inf || w_cb.is_zero) begin
      w_spec_c = {w_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (w_ca.is_zero || w_cb.is_inf) begin
      w_spec_c = {w_sign, {(EXP_W + MANT_W){1'b0}}};
    end else begin
      w_special = 1'b0;
    end
  end

  assign w_load = (r_state == S_IDLE) && start && !w_special;

  mant_div_core #(
    .W(MANT_W + 1)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (w_load),
    .dividend(w_ma),
    .divisor (r_mb),
    .q       (w_q),
    .last    (w_last)
  );

  // Normalise the quotient (range (2^23, 2^25)) and clamp the exponent.
  always_comb begin
    w_ex   = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb}) +
             (w_q[QW-1] ? BIAS_HI : BIAS_LO);
    w_mant = w_q[QW-1] ? w_q[QW-2:1] : w_q[QW-3:0];
    if (!w_ex[EXW-1] && (w_ex >= EX_MAX)) begin
      w_norm_c = {r_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (w_ex[EXW-1] || (w_ex == '0)) begin
      w_norm_c = {r_sign, {(EXP_W + MANT_W){1'b0}}};
    end else begin
      w_norm_c = {r_sign, w_ex[EXP_W-1:0], w_mant};
    end
  end

  // Control FSM with registered busy/done/c outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_c     <= '0;
      r_sign  <= 1'b0;
      r_ea    <= '0;
      r_eb    <= '0;
      r_mb    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign <= w_sign;
            r_ea   <= fp_exp(a);
            r_eb   <= fp_exp(b);
            r_mb   <= w_mb;
            r_busy <= 1'b1;
            if (w_special) begin
              r_c     <= w_spec_c;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (w_last) begin
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          r_c     <= w_norm_c;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign c    = r_c;

endmodule

// File: tb/tb_ieee_divide.sv
// Self-checking bench for ieee_divide: directed transactions with literal
// expectations plus a cycle-level reference model checked every cycle.
module tb_ieee_divide;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] c;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  ieee_divide dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .c    (c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: exact integer quotient of the significands, truncated.
  function automatic bit model_special(input logic [31:0] x, input logic [31:0] y);
    return (x[30:23] == 8'd0) || (x[30:23] == 8'd255) ||
           (y[30:23] == 8'd0) || (y[30:23] == 8'd255);
  endfunction

  function automatic logic [31:0] model_div(input logic [31:0] x, input logic [31:0] y);
    logic s;
    int ex, ey, e;
    bit xz, xi, xn, yz, yi, yn;
    longint mx, my, qq, mant;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0);  xi = (ex == 255) && (x[22:0] == 0); xn = (ex == 255) && (x[22:0] != 0);
    yz = (ey == 0);  yi = (ey == 255) && (y[22:0] == 0); yn = (ey == 255) && (y[22:0] != 0);
    if (xn || yn || (xz && yz) || (xi && yi)) return 32'h7FC00000;
    if (xi || yz) return {s, 31'h7F800000};
    if (xz || yi) return {s, 31'h0};
    mx = 64'h800000 + longint'(x[22:0]);
    my = 64'h800000 + longint'(y[22:0]);
    qq = (mx * 64'd16777216) / my;
    e  = ex - ey + 127;
    if (qq >= 64'd16777216) mant = (qq / 2) % 64'd8388608;
    else begin
      mant = qq % 64'd8388608;
      e = e - 1;
    end
    if (e >= 255) return {s, 31'h7F800000};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), 23'(mant)};
  endfunction

  // Cycle model: what busy/done/c must be after each rising edge.
  logic        m_act = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_c = '0;
  logic [31:0] m_res = '0;
  int          m_k = 0;
  int          m_lat = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_act <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; m_c <= '0; m_k <= 0;
    end else if (!m_act) begin
      m_done <= 1'b0;
      if (start) begin
        m_act  <= 1'b1;
        m_k    <= 0;
        m_busy <= 1'b1;
        m_res  <= model_div(a, b);
        if (model_special(a, b)) begin
          m_lat  <= 0;
          m_done <= 1'b1;
          m_c    <= model_div(a, b);
        end else begin
          m_lat  <= 27;
        end
      end
    end else begin
      m_k <= m_k + 1;
      if (m_k + 1 == m_lat + 1) begin
        m_act <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
      end else if (m_k + 1 == m_lat) begin
        m_done <= 1'b1;
        m_c    <= m_res;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
      chk("cyc_done", {31'd0, done}, {31'd0, m_done});
      chk("cyc_c", c, m_c);
    end
  end

  // mode 0: plain op; 1: extra start at edge 10 and in DONE; 2: rst at edge 12.
  task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tb_op,
                        input logic [31:0] exp_c, input int exp_edge, input int mode);
    int n;
    int nbusy;
    bit seen;
    @(negedge clk);
    a = ta; b = tb_op; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;
    n = 0; nbusy = 0; seen = 1'b0;
    while (n < 60) begin
      if (busy) nbusy++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      start = 1'b0;
      if (mode == 1 && n == 9) begin
        start = 1'b1; a = 32'h3F800000; b = 32'h40400000;
      end
      if (mode == 2 && n == 11) rst = 1'b1;
      if (mode == 2 && n == 12) begin
        chk({name, "_rst_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_rst_done"}, {31'd0, done}, 32'd0);
        chk({name, "_rst_c"}, c, 32'd0);
        rst = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (mode == 2) begin
      chk({name, "_no_done"}, {31'd0, seen}, 32'd0);
    end else begin
      chk({name, "_done_seen"}, {31'd0, seen}, 32'd1);
      chk({name, "_c"}, c, exp_c);
      chk({name, "_edge"}, n, exp_edge);
      chk({name, "_busy_cycles"}, nbusy, exp_edge + 1);
      if (mode == 1) begin
        // start while in DONE must be dropped
        start = 1'b1; a = 32'h3F800000; b = 32'h40400000;
        @(negedge clk);
        start = 1'b0;
        chk({name, "_done_start_ignored"}, {31'd0, busy}, 32'd0);
        chk({name, "_c_held"}, c, exp_c);
      end
    end
    $display("txn %s a=%h b=%h c=%h done_edge=%0d busy_cycles=%0d", name, ta, tb_op, c, n, nbusy);
  endtask

  initial begin
    // Pin the model to hand-computed values.
    chk("model_6_2", model_div(32'h40C00000, 32'h40000000), 32'h40400000);
    chk("model_1_3", model_div(32'h3F800000, 32'h40400000), 32'h3EAAAAAA);
    chk("model_ovf", model_div(32'h7F000000, 32'h3E800000), 32'h7F800000);
    chk("model_unf", model_div(32'h00800000, 32'h4B000000), 32'h00000000);
    chk("model_div0", model_div(32'hBF800000, 32'h00000000), 32'hFF800000);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_c", c, 32'd0);
    chk_en = 1'b1;
    rst = 1'b0;

    run_op("six_by_two",  32'h40C00000, 32'h40000000, 32'h40400000, 27, 0);
    run_op("one_third",   32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 27, 0);
    run_op("neg_six_two", 32'hC0C00000, 32'h40000000, 32'hC0400000, 27, 0);
    run_op("neg_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 0, 0);
    run_op("zero_zero",   32'h00000000, 32'h00000000, 32'h7FC00000, 0, 0);
    run_op("nan_in",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 0, 0);
    run_op("inf_inf",     32'h7F800000, 32'h7F800000, 32'h7FC00000, 0, 0);
    run_op("inf_by_two",  32'h7F800000, 32'h40000000, 32'h7F800000, 0, 0);
    run_op("neg_by_inf",  32'hBF800000, 32'h7F800000, 32'h80000000, 0, 0);
    run_op("nzero_two",   32'h80000000, 32'h40000000, 32'h80000000, 0, 0);
    run_op("denorm_a",    32'h00000001, 32'h3F800000, 32'h00000000, 0, 0);
    run_op("denorm_b",    32'h3F800000, 32'h00000001, 32'h7F800000, 0, 0);
    run_op("overflow",    32'h7F000000, 32'h3E800000, 32'h7F800000, 27, 0);
    run_op("underflow",   32'h00800000, 32'h4B000000, 32'h00000000, 27, 0);
    run_op("mid_start",   32'h40C00000, 32'h40000000, 32'h40400000, 27, 1);
    run_op("after_ign",   32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 27, 0);
    run_op("rst_abort",   32'h40C00000, 32'h40000000, 32'h00000000, 0, 2);
    run_op("post_rst",    32'h40C00000, 32'h40000000, 32'h40400000, 27, 0);

    repeat (4) @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
